// File: rtl/a2d_pkg.sv
// -----------------------------------------------------------------------------
// a2d_pkg
// Shared types and helpers for the ADC128S round-robin conversion sequencer.
//   state_t  : sequencer FSM states
//   sel_t    : rotation pointer (which result register is being refreshed)
//   build_cmd: ADC128S control word for a given 3-bit channel address
//   next_sel : rotation order LFT -> RGHT -> BATT -> LFT
// -----------------------------------------------------------------------------
package a2d_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        TX1  = 3'd1,
        GAP  = 3'd2,
        TX2  = 3'd3,
        DONE = 3'd4
    } state_t;

    typedef enum logic [1:0] {
        SEL_LFT  = 2'd0,
        SEL_RGHT = 2'd1,
        SEL_BATT = 2'd2
    } sel_t;

    localparam logic [2:0] LFT_CH_DEF  = 3'd0;
    localparam logic [2:0] RGHT_CH_DEF = 3'd4;
    localparam logic [2:0] BATT_CH_DEF = 3'd5;

    // The ADC128S takes its channel address in bits [13:11] of the word.
    function automatic logic [15:0] build_cmd(input logic [2:0] ch);
        return {2'b00, ch, 11'h000};
    endfunction

    function automatic sel_t next_sel(input sel_t s);
        sel_t n;
        case (s)
            SEL_LFT:  n = SEL_RGHT;
            SEL_RGHT: n = SEL_BATT;
            default:  n = SEL_LFT;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/a2d_sequencer.sv
// -----------------------------------------------------------------------------
// a2d_sequencer
// Round-robin conversion scheduler for the ADC128S behind an external SPI
// master. Each accepted nxt runs two SPI transactions on the current channel
// (the ADC answers with the previously addressed channel, so the first reply
// is discarded) and stores the 12-bit result of the second.
//
// Ports
//   clk, rst_n     : clock, asynchronous active-low reset
//   nxt            : conversion request, sampled only while idle
//   wrt            : one-cycle start strobe to the SPI master
//   cmd[15:0]      : word sent to the ADC, stable for the whole conversion
//   done           : SPI transaction complete pulse
//   rd_data[15:0]  : word received in the transaction just completed
//   lft_ld, rght_ld, batt [11:0] : latest result per channel
//   cnv_cmplt      : one-cycle pulse, coincident with a result update
//   tmo_err        : sticky flag, set when done fails to arrive in time
// -----------------------------------------------------------------------------
module a2d_sequencer
    import a2d_pkg::*;
#(
    parameter logic [2:0] LFT_CH  = LFT_CH_DEF,
    parameter logic [2:0] RGHT_CH = RGHT_CH_DEF,
    parameter logic [2:0] BATT_CH = BATT_CH_DEF,
    parameter int         GAP_CYC = 2,
    parameter int         TMO_CYC = 4095
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        nxt,
    output logic        wrt,
    output logic [15:0] cmd,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic [11:0] lft_ld,
    output logic [11:0] rght_ld,
    output logic [11:0] batt,
    output logic        cnv_cmplt,
    output logic        tmo_err
);

    localparam int TMO_W = $clog2(TMO_CYC + 1);
    localparam int GAP_W = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TMO_CYC - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_CYC - 1);

    state_t            state_q, state_d;
    sel_t              sel_q, sel_d;
    logic [15:0]       cmd_q, cmd_d;
    logic              wrt_q, wrt_d;
    logic [11:0]       lft_q, lft_d;
    logic [11:0]       rght_q, rght_d;
    logic [11:0]       batt_q, batt_d;
    logic              cmplt_q, cmplt_d;
    logic              tmo_err_q, tmo_err_d;
    logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
    logic [GAP_W-1:0]  gap_cnt_q, gap_cnt_d;

    logic              tmo_hit;
    logic              gap_end;
    logic              unused_rd_hi;

    // Upper nibble of the ADC reply carries no conversion data.
    assign unused_rd_hi = ^rd_data[15:12];

    // tmo_cnt_q counts elapsed cycles of the current transaction; the last
    // allowed cycle is TMO_CYC-1, so a transaction occupies at most TMO_CYC clocks.
    assign tmo_hit = (tmo_cnt_q == TMO_LAST);
    assign gap_end = (gap_cnt_q == GAP_LAST);

    function automatic logic [2:0] sel_chan(input sel_t s);
        logic [2:0] ch;
        case (s)
            SEL_RGHT: ch = RGHT_CH;
            SEL_BATT: ch = BATT_CH;
            default:  ch = LFT_CH;
        endcase
        return ch;
    endfunction

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            sel_q     <= SEL_LFT;
            cmd_q     <= 16'h0000;
            wrt_q     <= 1'b0;
            lft_q     <= 12'h000;
            rght_q    <= 12'h000;
            batt_q    <= 12'h000;
            cmplt_q   <= 1'b0;
            tmo_err_q <= 1'b0;
            tmo_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            cmd_q     <= cmd_d;
            wrt_q     <= wrt_d;
            lft_q     <= lft_d;
            rght_q    <= rght_d;
            batt_q    <= batt_d;
            cmplt_q   <= cmplt_d;
            tmo_err_q <= tmo_err_d;
            tmo_cnt_q <= tmo_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state logic; done has priority over a timeout landing the same cycle.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (nxt) state_d = TX1;
            TX1: begin
                if (done)         state_d = GAP;
                else if (tmo_hit) state_d = IDLE;
            end
            GAP:  if (gap_end) state_d = TX2;
            TX2: begin
                if (done)         state_d = DONE;
                else if (tmo_hit) state_d = IDLE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Output / datapath logic. All outputs are registered, so strobes decided
    // here appear in the cycle after the decision (wrt in the first TX cycle,
    // cnv_cmplt together with the new result in DONE).
    always_comb begin
        sel_d     = sel_q;
        cmd_d     = cmd_q;
        wrt_d     = 1'b0;
        lft_d     = lft_q;
        rght_d    = rght_q;
        batt_d    = batt_q;
        cmplt_d   = 1'b0;
        tmo_err_d = tmo_err_q;
        tmo_cnt_d = tmo_cnt_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (nxt) begin
                    cmd_d     = build_cmd(sel_chan(sel_q));
                    wrt_d     = 1'b1;
                    tmo_cnt_d = '0;
                end
            end
            TX1: begin
                // Reply of the first transaction belongs to the previous
                // channel and is dropped.
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (done) begin
                    gap_cnt_d = '0;
                end else if (tmo_hit) begin
                    tmo_err_d = 1'b1;
                    sel_d     = next_sel(sel_q);
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt_q + 1'b1;
                if (gap_end) begin
                    wrt_d     = 1'b1;
                    tmo_cnt_d = '0;
                end
            end
            TX2: begin
                tmo_cnt_d = tmo_cnt_q + 1'b1;
                if (done) begin
                    cmplt_d = 1'b1;
                    case (sel_q)
                        SEL_RGHT: rght_d = rd_data[11:0];
                        SEL_BATT: batt_d = rd_data[11:0];
                        default:  lft_d  = rd_data[11:0];
                    endcase
                end else if (tmo_hit) begin
                    // A stuck channel still gives way to the next one.
                    tmo_err_d = 1'b1;
                    sel_d     = next_sel(sel_q);
                end
            end
            DONE: begin
                sel_d = next_sel(sel_q);
            end
            default: ;
        endcase
    end

    assign wrt       = wrt_q;
    assign cmd       = cmd_q;
    assign lft_ld    = lft_q;
    assign rght_ld   = rght_q;
    assign batt      = batt_q;
    assign cnv_cmplt = cmplt_q;
    assign tmo_err   = tmo_err_q;

endmodule

// File: tb/tb_a2d_sequencer.sv
// -----------------------------------------------------------------------------
// tb_a2d_sequencer
// Bench for a2d_sequencer. A behavioural SPI-master + ADC128S stand-in answers
// each wrt after a random latency with the data of the channel addressed by the
// previous transaction. A channel-level reference model (rotation index, table
// of expected results) is checked at every wrt and every cnv_cmplt.
// -----------------------------------------------------------------------------
module tb_a2d_sequencer;

    localparam int TMO_CYC = 4095;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        nxt = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [11:0] lft_ld, rght_ld, batt;
    logic        cnv_cmplt, tmo_err;

    always #5 clk = ~clk;

    a2d_sequencer dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .nxt       (nxt),
        .wrt       (wrt),
        .cmd       (cmd),
        .done      (done),
        .rd_data   (rd_data),
        .lft_ld    (lft_ld),
        .rght_ld   (rght_ld),
        .batt      (batt),
        .cnv_cmplt (cnv_cmplt),
        .tmo_err   (tmo_err)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h t=%0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: analog value per ADC channel, rotation table, results.
    logic [11:0] adc_val [8];
    logic [2:0]  chs [3];
    logic [11:0] exp_reg [3];
    int          exp_ptr = 0;
    int          wrt_cnt = 0;
    int          cmplt_cnt = 0;
    logic [15:0] last_cmd = 16'h0000;
    bit          stall = 1'b0;

    // SPI master + ADC128S stand-in
    initial begin : spi_model
        bit          busy;
        int          lat;
        logic [2:0]  prev_ch;
        logic [2:0]  cur_ch;
        busy = 1'b0; lat = 0; prev_ch = 3'd0; cur_ch = 3'd0;
        forever begin
            @(posedge clk); #1;
            done = 1'b0;
            if (!rst_n) begin
                busy = 1'b0;
                prev_ch = 3'd0;
                continue;
            end
            if (busy) begin
                if (lat == 0) begin
                    if (!stall) begin
                        done = 1'b1;
                        rd_data = {4'($urandom), adc_val[prev_ch]};
                    end
                    prev_ch = cur_ch;
                    busy = 1'b0;
                end else begin
                    lat--;
                end
            end
            if (wrt) begin
                chk("wrt_overlap", 32'(busy), 32'd0);
                busy = 1'b1;
                cur_ch = cmd[13:11];
                lat = $urandom_range(12, 2);
            end
        end
    end

    // Monitor: checks command words and result registers against the model.
    initial begin : monitor
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (wrt) begin
                    wrt_cnt++;
                    last_cmd = cmd;
                    chk("cmd", 32'(cmd), 32'({2'b00, chs[exp_ptr], 11'h000}));
                end
                if (done) chk("cmd_hold", 32'(cmd), 32'(last_cmd));
                if (cnv_cmplt) begin
                    cmplt_cnt++;
                    exp_reg[exp_ptr] = adc_val[chs[exp_ptr]];
                    exp_ptr = (exp_ptr + 1) % 3;
                    chk("lft_ld", 32'(lft_ld), 32'(exp_reg[0]));
                    chk("rght_ld", 32'(rght_ld), 32'(exp_reg[1]));
                    chk("batt", 32'(batt), 32'(exp_reg[2]));
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog act=running exp=finished");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic pulse_nxt();
        nxt = 1'b1;
        tick();
        nxt = 1'b0;
    endtask

    task automatic wait_cmplt(input string tag, input int budget);
        int n;
        n = 0;
        while (!cnv_cmplt && n < budget) begin
            tick();
            n++;
        end
        if (!cnv_cmplt) chk(tag, 32'd0, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_wrt"}, 32'(wrt), 32'd0);
        chk({tag, "_cmd"}, 32'(cmd), 32'd0);
        chk({tag, "_lft"}, 32'(lft_ld), 32'd0);
        chk({tag, "_rght"}, 32'(rght_ld), 32'd0);
        chk({tag, "_batt"}, 32'(batt), 32'd0);
        chk({tag, "_cmplt"}, 32'(cnv_cmplt), 32'd0);
        chk({tag, "_tmo"}, 32'(tmo_err), 32'd0);
    endtask

    task automatic model_reset();
        exp_ptr = 0;
        for (int i = 0; i < 3; i++) exp_reg[i] = 12'h000;
    endtask

    initial begin : stim
        int w0, c0, n;
        logic [11:0] sav [3];
        logic [15:0] seq [3];
        chs[0] = 3'd0; chs[1] = 3'd4; chs[2] = 3'd5;
        seq[0] = 16'h0000; seq[1] = 16'h2000; seq[2] = 16'h2800;
        for (int i = 0; i < 8; i++) adc_val[i] = 12'($urandom);
        model_reset();

        // Reset state, then a single left conversion
        rst_n = 1'b0;
        repeat (3) tick();
        check_reset_outputs("rst");
        rst_n = 1'b1;
        adc_val[0] = 12'h156;
        tick();
        w0 = wrt_cnt; c0 = cmplt_cnt;
        pulse_nxt();
        chk("wrt_latency", 32'(wrt), 32'd1);
        chk("first_cmd", 32'(cmd), 32'h0000);
        wait_cmplt("t1_cmplt_timeout", 200);
        tick();
        chk("t1_wrt_cnt", 32'(wrt_cnt - w0), 32'd2);
        chk("t1_cmplt_cnt", 32'(cmplt_cnt - c0), 32'd1);
        chk("t1_lft", 32'(lft_ld), 32'h156);
        chk("t1_rght", 32'(rght_ld), 32'h000);
        chk("t1_batt", 32'(batt), 32'h000);

        // Reset asserted during GAP of the right-channel conversion
        pulse_nxt();
        n = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) break;
            n++;
        end
        if (n >= 40) chk("gap_done_timeout", 32'd0, 32'd1);
        tick();
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        model_reset();
        repeat (2) tick();
        rst_n = 1'b1;
        tick();

        // Three pulses, one per channel
        adc_val[0] = 12'h200; adc_val[4] = 12'h140; adc_val[5] = 12'hC00;
        c0 = cmplt_cnt;
        for (int k = 0; k < 3; k++) begin
            pulse_nxt();
            chk("cmd_seq", 32'(cmd), 32'(seq[k]));
            wait_cmplt("t2_cmplt_timeout", 200);
            tick();
        end
        chk("t2_cmplt_cnt", 32'(cmplt_cnt - c0), 32'd3);
        chk("t2_lft", 32'(lft_ld), 32'h200);
        chk("t2_rght", 32'(rght_ld), 32'h140);
        chk("t2_batt", 32'(batt), 32'hC00);

        // nxt held high: back-to-back conversions, one idle cycle between
        w0 = wrt_cnt; c0 = cmplt_cnt;
        nxt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            wait_cmplt("t3_cmplt_timeout", 200);
            if (k == 3) begin
                nxt = 1'b0;
            end else begin
                n = 0;
                do begin
                    tick();
                    n++;
                end while (!wrt && n < 10);
                chk("idle_gap", 32'(n), 32'd2);
            end
        end
        nxt = 1'b0;
        repeat (30) tick();
        chk("t3_cmplt_cnt", 32'(cmplt_cnt - c0), 32'd4);
        chk("t3_wrt_cnt", 32'(wrt_cnt - w0), 32'd8);

        // nxt during TX2 is ignored
        w0 = wrt_cnt; c0 = cmplt_cnt;
        pulse_nxt();
        for (int i = 0; i < 60; i++) begin
            if (wrt_cnt == w0 + 2) break;
            tick();
        end
        pulse_nxt();
        wait_cmplt("t4_cmplt_timeout", 200);
        repeat (30) tick();
        chk("t4_cmplt_cnt", 32'(cmplt_cnt - c0), 32'd1);
        chk("t4_wrt_cnt", 32'(wrt_cnt - w0), 32'd2);

        // done never arrives: timeout path
        for (int i = 0; i < 3; i++) sav[i] = exp_reg[i];
        c0 = cmplt_cnt;
        stall = 1'b1;
        pulse_nxt();
        n = 0;
        while (!tmo_err && n < TMO_CYC + 50) begin
            tick();
            n++;
        end
        chk("tmo_latency", 32'(n), 32'(TMO_CYC));
        chk("tmo_err_set", 32'(tmo_err), 32'd1);
        chk("tmo_no_cmplt", 32'(cmplt_cnt - c0), 32'd0);
        chk("tmo_lft_keep", 32'(lft_ld), 32'(sav[0]));
        chk("tmo_rght_keep", 32'(rght_ld), 32'(sav[1]));
        chk("tmo_batt_keep", 32'(batt), 32'(sav[2]));
        stall = 1'b0;
        exp_ptr = (exp_ptr + 1) % 3;
        pulse_nxt();
        wait_cmplt("t5_cmplt_timeout", 200);
        tick();
        chk("tmo_err_sticky", 32'(tmo_err), 32'd1);

        // Randomized conversions with stray nxt pulses mid-conversion
        for (int i = 0; i < 20; i++) begin
            for (int c = 0; c < 8; c++) adc_val[c] = 12'($urandom);
            repeat ($urandom_range(3, 0)) tick();
            c0 = cmplt_cnt;
            pulse_nxt();
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(5, 1)) tick();
                pulse_nxt();
            end
            wait_cmplt("rnd_cmplt_timeout", 200);
            tick();
            chk("rnd_cmplt_cnt", 32'(cmplt_cnt - c0), 32'd1);
        end

        repeat (5) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
